fetch_sequencer: RTL

Drives the instruction register's byte-load port from the memory side. On `start` it reads two consecutive bytes at the current program counter: upper byte first, then lower. It presents each byte on `ir_data` with a one-cycle `load_iru` or `load_irl` strobe, advances the PC, and pulses `fetch_done`. It sits between the memory/MDR path and `instruction_register`, and is the producer for that register's `load_iru`/`load_irl`/`mdr_data` inputs.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_counter.sv | 33 +++
 rtl/fetch_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_HI = 3'd1,
    LD_HI = 3'd2,
    RD_LO = 3'd3,
    LD_LO = 3'd4,
    DONE  = 3'd5
  } fetch_state_t;

  // True in the two states that wait for a memory byte.
  function automatic logic is_read_state(input fetch_state_t s);
    return (s == RD_HI) || (s == RD_LO);
  endfunction

endpackage

// File: rtl/pc_counter.sv
// 8-bit program counter: parallel load has priority over increment,
// increment wraps modulo 256.
module pc_counter
  import fetch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PC_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              inc,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] q
);

  logic [BYTE_W-1:0] r_pc;

  // PC register: reset value, then load, then increment, else hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= PC_RESET;
    end else if (load) begin
      r_pc <= d;
    end else if (inc) begin
      r_pc <= r_pc + 8'd1;
    end else begin
      r_pc <= r_pc;
    end
  end

  assign q = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetches a 2-byte instruction (upper byte, then lower) from memory at the
// PC and hands each byte to the instruction register with a load strobe.
// Every output is either a register or a decode of the state register.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PC_RESET = 8'h00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              pc_load,
  input  logic [BYTE_W-1:0] pc_in,
  output logic              mem_req,
  output logic [BYTE_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [BYTE_W-1:0] mem_data,
  output logic [BYTE_W-1:0] ir_data,
  output logic              load_iru,
  output logic              load_irl,
  output logic [BYTE_W-1:0] pc,
  output logic              busy,
  output logic              fetch_done
);

  fetch_state_t      r_state;
  fetch_state_t      w_next;
  logic [BYTE_W-1:0] r_data;
  logic [BYTE_W-1:0] w_pc;
  logic              w_pc_load;
  logic              w_pc_inc;
  logic              w_capture;

  pc_counter #(
    .PC_RESET(PC_RESET)
  ) u_pc (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_pc_load),
    .inc    (w_pc_inc),
    .d      (pc_in),
    .q      (w_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath control; pc_load beats start in IDLE.
  always_comb begin
    w_next    = r_state;
    w_pc_load = 1'b0;
    w_pc_inc  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (pc_load) begin
          w_pc_load = 1'b1;
        end else if (start) begin
          w_next = RD_HI;
        end else begin
          w_next = IDLE;
        end
      end
      RD_HI, RD_LO: begin
        if (mem_ready) begin
          w_capture = 1'b1;
          w_pc_inc  = 1'b1;
          w_next    = (r_state == RD_HI) ? LD_HI : LD_LO;
        end else begin
          w_next = r_state;
        end
      end
      LD_HI:   w_next = RD_LO;
      LD_LO:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Data register: holds the last byte read until the next capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= 8'h00;
    end else if (w_capture) begin
      r_data <= mem_data;
    end else begin
      r_data <= r_data;
    end
  end

  assign mem_req    = is_read_state(r_state);
  assign mem_addr   = w_pc;
  assign pc         = w_pc;
  assign ir_data    = r_data;
  assign load_iru   = (r_state == LD_HI);
  assign load_irl   = (r_state == LD_LO);
  assign fetch_done = (r_state == DONE);
  assign busy       = (r_state != IDLE);

endmodule
